// File: rtl/ex_muldiv_unit.sv
// Execute-stage iterative multiply/divide unit driving the HI/LO registers.
// One radix-2 step per cycle; signed ops run on magnitudes and are corrected in FIX.
module ex_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             abort,
    input  logic             we_hi,
    input  logic             we_lo,
    input  logic [WIDTH-1:0] wdata,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic             is_div;
    logic             neg_q;
    logic             neg_r;
    logic             dbz_q;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] opnd;

    logic             sgn_in;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   shl;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] nxt_hi;
    logic [WIDTH-1:0] nxt_lo;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0] fix_hi;
    logic [WIDTH-1:0] fix_lo;

    assign sgn_in = ~op[0];
    assign mag_a  = (sgn_in && operand_a[WIDTH-1]) ? -operand_a : operand_a;
    assign mag_b  = (sgn_in && operand_b[WIDTH-1]) ? -operand_b : operand_b;

    // Multiply keeps the multiplier in acc_lo; divide keeps the dividend/quotient there.
    always_comb begin
        add_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
        shl     = {acc_hi, acc_lo[WIDTH-1]};
        diff    = shl - {1'b0, opnd};
        nxt_hi  = add_sum[WIDTH:1];
        nxt_lo  = {add_sum[0], acc_lo[WIDTH-1:1]};
        if (is_div) begin
            if (!diff[WIDTH]) begin
                nxt_hi = diff[WIDTH-1:0];
                nxt_lo = {acc_lo[WIDTH-2:0], 1'b1};
            end else begin
                nxt_hi = shl[WIDTH-1:0];
                nxt_lo = {acc_lo[WIDTH-2:0], 1'b0};
            end
        end
    end

    always_comb begin
        prod = {acc_hi, acc_lo};
        if (neg_q) prod = -prod;
        fix_hi = prod[2*WIDTH-1:WIDTH];
        fix_lo = prod[WIDTH-1:0];
        if (is_div) begin
            fix_lo = neg_q ? -acc_lo : acc_lo;
            fix_hi = neg_r ? -acc_hi : acc_hi;
            if (dbz_q) fix_lo = '1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            dbz_q  <= 1'b0;
            acc_hi <= '0;
            acc_lo <= '0;
            opnd   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start && !abort) begin
                        is_div <= op[1];
                        neg_q  <= sgn_in & (operand_a[WIDTH-1] ^ operand_b[WIDTH-1]);
                        neg_r  <= sgn_in & operand_a[WIDTH-1];
                        dbz_q  <= op[1] && (operand_b == '0);
                        acc_hi <= '0;
                        acc_lo <= op[1] ? mag_a : mag_b;
                        opnd   <= op[1] ? mag_b : mag_a;
                        cnt    <= '0;
                        state  <= S_CALC;
                    end
                end
                S_CALC: begin
                    if (abort) begin
                        state <= S_IDLE;
                    end else begin
                        acc_hi <= nxt_hi;
                        acc_lo <= nxt_lo;
                        cnt    <= cnt + 1'b1;
                        if (cnt == CW'(WIDTH - 1)) state <= S_FIX;
                    end
                end
                S_FIX:   state <= abort ? S_IDLE : S_DONE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // MTHI/MTLO are only honoured outside an operation; FIX result wins otherwise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi <= '0;
            lo <= '0;
        end else if (state == S_FIX && !abort) begin
            hi <= fix_hi;
            lo <= fix_lo;
        end else if (state == S_IDLE || state == S_DONE) begin
            if (we_hi) hi <= wdata;
            if (we_lo) lo <= wdata;
        end
    end

    assign busy        = (state == S_CALC) || (state == S_FIX);
    assign done        = (state == S_DONE);
    assign div_by_zero = (state == S_DONE) && dbz_q;
    assign stall       = rst && (((state == S_IDLE) && start && !abort) || busy);

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit with an expected-result queue.
module tb_ex_muldiv_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   op = 2'd0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         abort = 1'b0;
    logic         we_hi = 1'b0;
    logic         we_lo = 1'b0;
    logic [W-1:0] wdata = '0;
    logic         stall;
    logic         busy;
    logic         done;
    logic         div_by_zero;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   passed = 0;
    int   fails  = 0;

    ex_muldiv_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op),
        .operand_a(a), .operand_b(b), .abort(abort),
        .we_hi(we_hi), .we_lo(we_lo), .wdata(wdata),
        .stall(stall), .busy(busy), .done(done),
        .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic [W-1:0] h, input logic [W-1:0] l, input logic z);
        exp_t e;
        e.hi = h;
        e.lo = l;
        e.dbz = z;
        return e;
    endfunction

    function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t e;
        longint sx;
        longint sy;
        longint p;
        logic [63:0] u;
        sx = $signed(x);
        sy = $signed(y);
        e = mk('0, '0, 1'b0);
        case (o)
            2'd0: begin
                p = sx * sy;
                e.hi = p[63:32];
                e.lo = p[31:0];
            end
            2'd1: begin
                u = {32'b0, x} * {32'b0, y};
                e.hi = u[63:32];
                e.lo = u[31:0];
            end
            default: begin
                if (y == '0) begin
                    e = mk(x, '1, 1'b1);
                end else if (o == 2'd2) begin
                    p = sx / sy;
                    e.lo = p[31:0];
                    p = sx % sy;
                    e.hi = p[31:0];
                end else begin
                    e.lo = x / y;
                    e.hi = x % y;
                end
            end
        endcase
        return e;
    endfunction

    // Called at a negedge with the DUT in IDLE.
    task automatic start_op(input logic [1:0] o, input logic [W-1:0] x,
                            input logic [W-1:0] y, input exp_t e, input bit push);
        op = o;
        a = x;
        b = y;
        start = 1'b1;
        if (push) sb_q.push_back(e);
        #1 chk("stall_on_start", stall, 1);
    endtask

    // Returns at the negedge where done is high; poke>0 writes MTLO in that CALC cycle.
    task automatic wait_done(input string tag, input int poke);
        int stalls;
        int cyc;
        bit seen;
        exp_t e;
        logic [W-1:0] lo_snap;
        stalls = 0;
        cyc = 0;
        seen = 1'b0;
        lo_snap = '0;
        for (int c = 1; c <= 40 && !seen; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (poke > 0 && c == poke + 1) begin
                we_lo = 1'b0;
                chk({tag, "_mtlo_busy"}, lo, lo_snap);
            end
            if (done) begin
                seen = 1'b1;
                cyc = c;
            end else if (stall) begin
                stalls++;
            end
            if (poke > 0 && c == poke) begin
                lo_snap = lo;
                we_lo = 1'b1;
                wdata = 32'hDEAD_BEEF;
            end
        end
        chk({tag, "_latency"}, cyc, 34);
        chk({tag, "_stall_cycles"}, stalls, 33);
        if (seen && sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk({tag, "_hi"}, hi, e.hi);
            chk({tag, "_lo"}, lo, e.lo);
            chk({tag, "_dbz"}, div_by_zero, e.dbz);
            chk({tag, "_stall_done"}, stall, 0);
        end else if (sb_q.size() > 0) begin
            void'(sb_q.pop_front());
        end
    endtask

    initial begin
        logic [W-1:0] lo_b;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        int ndone;

        start = 1'b1;
        #2;
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        chk("rst_done", done, 0);
        chk("rst_dbz", div_by_zero, 0);
        chk("rst_busy", busy, 0);
        chk("rst_stall", stall, 0);
        repeat (2) @(negedge clk);
        start = 1'b0;
        rst = 1'b1;
        @(negedge clk);

        start_op(2'd0, 32'h7, 32'hFFFF_FFFD, mk(32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0), 1'b1);
        wait_done("mult", 0);
        @(negedge clk);
        chk("done_one_cycle", done, 0);

        start_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, mk(32'hFFFF_FFFE, 32'h1, 1'b0), 1'b1);
        wait_done("multu", 0);
        @(negedge clk);
        start_op(2'd2, 32'hFFFF_FFF9, 32'h2, mk(32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0), 1'b1);
        wait_done("div_neg", 0);
        @(negedge clk);
        start_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, mk(32'h0, 32'h8000_0000, 1'b0), 1'b1);
        wait_done("div_ovf", 0);
        @(negedge clk);
        start_op(2'd3, 32'd100, 32'h0, mk(32'h64, 32'hFFFF_FFFF, 1'b1), 1'b1);
        wait_done("divu_zero", 0);
        @(negedge clk);
        start_op(2'd2, 32'hFFFF_FF9C, 32'h0, model(2'd2, 32'hFFFF_FF9C, 32'h0), 1'b1);
        wait_done("div_zero_neg", 0);

        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            ra = $urandom;
            rb = $urandom;
            start_op(i[1:0], ra, rb, model(i[1:0], ra, rb), 1'b1);
            wait_done("rand", 0);
        end

        @(negedge clk);
        we_hi = 1'b1;
        wdata = 32'h1234;
        @(negedge clk);
        we_hi = 1'b0;
        chk("mthi", hi, 32'h1234);
        lo_b = lo;
        start_op(2'd0, 32'h55, 32'h66, mk('0, '0, 1'b0), 1'b0);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_hi", hi, 32'h1234);
        chk("abort_lo", lo, lo_b);
        ndone = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("abort_no_done", ndone, 0);
        chk("abort_hi_late", hi, 32'h1234);

        start_op(2'd0, 32'h55, 32'h66, mk('0, '0, 1'b0), 1'b0);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b0;
        #1;
        chk("mrst_hi", hi, 0);
        chk("mrst_lo", lo, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_stall", stall, 0);
        chk("mrst_done", done, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        start_op(2'd0, 32'd3, 32'd5, mk(32'h0, 32'd15, 1'b0), 1'b1);
        wait_done("mtlo", 5);
        we_lo = 1'b1;
        wdata = 32'hCAFE_F00D;
        @(negedge clk);
        we_lo = 1'b0;
        chk("mtlo_in_done", lo, 32'hCAFE_F00D);
        chk("idle_after_done", busy, 0);
        start_op(2'd0, 32'd2, 32'hFFFF_FFFE, mk(32'hFFFF_FFFF, 32'hFFFF_FFFC, 1'b0), 1'b1);
        wait_done("b2b", 0);

        @(negedge clk);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- Execute-stage iterative multiply/divide unit; sits directly downstream of the ID/EX pipeline register.
- Consumes the latched operands r1/r2 and the decoded EX control: operation select and start.
- Produces the HI/LO registers read by MFHI/MFLO, plus a stall that freezes PC, IF/ID and ID/EX while an operation is in flight.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits; iteration count equals WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  EX-stage instruction is MULT/MULTU/DIV/DIVU.
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- operand_a  input  WIDTH  rs value, from ID/EX r1 after forwarding.
- operand_b  input  WIDTH  rt value, from ID/EX r2 after forwarding.
- abort  input  1  pipeline flush of the EX instruction; cancels the operation.
- we_hi  input  1  MTHI write enable.
- we_lo  input  1  MTLO write enable.
- wdata  input  WIDTH  MTHI/MTLO data.
- stall  output  1  hold the upstream pipeline.
- busy  output  1  state is CALC or FIX.
- done  output  1  one-cycle pulse; HI/LO updated this cycle.
- div_by_zero  output  1  valid with done; divisor was zero.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- States: IDLE, CALC, FIX, DONE. A 2-bit state register plus a log2(WIDTH)+1-bit iteration counter.
- Reset (rst low, asynchronous):
  - state=IDLE, counter=0, internal accumulators=0.
  - hi=0, lo=0, done=0, div_by_zero=0, busy=0.
  - stall is 0 while rst is low.
- IDLE:
  - On start=1 at edge E0, latch op and operand magnitudes.
  - Magnitude rule: signed ops (MULT, DIV) take the two's-complement absolute value of negative operands; record result signs.
  - Go to CALC with counter=0.
- CALC:
  - One radix-2 step per cycle: shift-add for multiply, restoring shift-subtract for divide.
  - Leaves for FIX after exactly WIDTH steps, at edge E32 for WIDTH=32.
- FIX, edge E33:
  - Apply sign correction. Product sign = a^b. Quotient sign = a^b. Remainder sign = sign of a.
  - Write HI/LO. Multiply: HI=upper word, LO=lower word. Divide: LO=quotient, HI=remainder.
  - Go to DONE.
- DONE:
  - done=1 for exactly this cycle; start is ignored.
  - Next edge goes to IDLE.
- Latency: start accepted at E0, HI/LO visible after E33, done high in the cycle after E33. Total 34 cycles.
- stall (combinational) = (state==IDLE && start && !abort) || state==CALC || state==FIX. It is low in DONE so the instruction retires.
- Divide by zero (divisor==0):
  - Still runs the full latency.
  - Result LO=all ones, HI=dividend unchanged in sign.
  - div_by_zero=1 alongside done. No trap.
- Signed overflow: 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0, flag=0.
- abort:
  - In CALC or FIX, the next edge goes to IDLE. HI/LO are not modified and done is not asserted.
  - In IDLE, start is suppressed.
- MTHI/MTLO:
  - Write on the edge only when state is IDLE or DONE.
  - Ignored while busy. This is a decided hazard rule; software never issues them then.
  - Simultaneous we_hi with start in IDLE: the write happens and the operation starts; the final result overwrites it.
- hi/lo are direct register outputs, with no combinational path from operands.

Test Plan:
- MULT a=0x00000007, b=0xFFFFFFFD -> done pulses 34 cycles after start; hi=0xFFFFFFFF, lo=0xFFFFFFEB; stall high for exactly 33 cycles.
- MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. Also 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU a=100, b=0 -> lo=0xFFFFFFFF, hi=0x00000064, div_by_zero=1 with done.
- Preload hi=0x1234 via MTHI, start MULT, assert abort at CALC cycle 10 -> IDLE next cycle, no done, hi=0x1234 and lo unchanged. Repeat with rst pulsed low mid-CALC -> all outputs 0 immediately.
- MTLO during CALC -> lo unchanged. MTLO in DONE cycle -> lo=wdata. Back-to-back MULT after DONE -> second start accepted in IDLE.
